// File: rtl/census_disparity.sv
// census_disparity: streaming stereo matcher over 8-bit census codes.
// For each left pixel, Hamming costs are formed against the current and the
// MAX_DISP-1 previous right codes. Candidates that would reach left of column 0
// are masked with a sentinel. A two-stage binary min-tree then selects the
// winner, lowest disparity first on a tie. The pipeline has a fixed latency of
// three cycles and no backpressure.
`timescale 1ns/1ps

module census_disparity #(
    parameter int ROW_SZ   = 320,
    parameter int COL_SZ   = 240,
    parameter int MAX_DISP = 16,
    localparam int DISP_W  = $clog2(MAX_DISP)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_left,
    input  logic [7:0]        in_right,
    input  logic [9:0]        in_x,
    input  logic [9:0]        in_y,
    input  logic              in_valid,
    output logic [DISP_W-1:0] out_disp,
    output logic [3:0]        out_cost,
    output logic [9:0]        out_x,
    output logic [9:0]        out_y,
    output logic              out_valid
);

    // Tree split: stage 2 takes the first ceil(DISP_W/2) levels, stage 3 the rest.
    localparam int L1 = (DISP_W + 1) / 2;
    localparam int L2 = DISP_W - L1;
    localparam int N2 = MAX_DISP >> L1;

    if (((MAX_DISP & (MAX_DISP - 1)) != 0) || (MAX_DISP < 4) || (MAX_DISP > 64) ||
        (ROW_SZ > 1024) || (COL_SZ > 1024)) begin : g_param_check
        $error("census_disparity: MAX_DISP must be a power of 2 in 4..64, frame <= 1024x1024");
    end

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
        return n;
    endfunction

    logic [7:0]        hist    [MAX_DISP-1];
    logic [7:0]        cand    [MAX_DISP];
    logic [3:0]        cost_d  [MAX_DISP];

    logic [3:0]        s1_cost [MAX_DISP];
    logic [9:0]        s1_x, s1_y;
    logic              s1_valid;

    logic [3:0]        s2n_cost [N2];
    logic [DISP_W-1:0] s2n_disp [N2];
    logic [3:0]        s2_cost  [N2];
    logic [DISP_W-1:0] s2_disp  [N2];
    logic [9:0]        s2_x, s2_y;
    logic              s2_valid;

    logic [3:0]        fin_cost;
    logic [DISP_W-1:0] fin_disp;

    // Right-census history: shifts one place per accepted pixel, cleared by reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every entry take its neighbour's pre-edge value.
        if (reset) begin
            for (int k = 0; k < MAX_DISP - 1; k++) hist[k] <= '0;
        end else if (in_valid) begin
            hist[0] <= in_right;
            for (int k = 1; k < MAX_DISP - 1; k++) hist[k] <= hist[k-1];
        end
    end

    // Masked Hamming cost for every candidate disparity.
    always_comb begin
        // NOTE: every element is assigned on each evaluation, so no latch is inferred.
        cand[0] = in_right;
        for (int d = 1; d < MAX_DISP; d++) cand[d] = hist[d-1];
        for (int d = 0; d < MAX_DISP; d++) begin
            cost_d[d] = (10'(d) > in_x) ? 4'hF : popcount8(in_left ^ cand[d]);
        end
    end

    // Stage 1 valid: cleared by reset so in-flight results are dropped.
    always_ff @(posedge clk) begin
        if (reset) s1_valid <= 1'b0;
        else       s1_valid <= in_valid;
    end

    // Stage 1 data: costs and coordinates, advancing every cycle.
    always_ff @(posedge clk) begin
        // NOTE: data registers are not reset; a cleared valid bit already discards them.
        s1_cost <= cost_d;
        s1_x    <= in_x;
        s1_y    <= in_y;
    end

    // First tree levels: adjacent pairs, lower cost wins, lower index on a tie.
    always_comb begin : stage2_tree
        logic [3:0]        wc [MAX_DISP];
        logic [DISP_W-1:0] wd [MAX_DISP];
        for (int i = 0; i < MAX_DISP; i++) begin
            wc[i] = s1_cost[i];
            wd[i] = DISP_W'(i);
        end
        for (int lvl = 0; lvl < L1; lvl++) begin
            for (int i = 0; i < (MAX_DISP >> (lvl + 1)); i++) begin
                if (wc[2*i+1] < wc[2*i]) begin
                    wc[i] = wc[2*i+1];
                    wd[i] = wd[2*i+1];
                end else begin
                    wc[i] = wc[2*i];
                    wd[i] = wd[2*i];
                end
            end
        end
        for (int g = 0; g < N2; g++) begin
            s2n_cost[g] = wc[g];
            s2n_disp[g] = wd[g];
        end
    end

    // Stage 2 valid.
    always_ff @(posedge clk) begin
        if (reset) s2_valid <= 1'b0;
        else       s2_valid <= s1_valid;
    end

    // Stage 2 data: partial minima and coordinates.
    always_ff @(posedge clk) begin
        s2_cost <= s2n_cost;
        s2_disp <= s2n_disp;
        s2_x    <= s1_x;
        s2_y    <= s1_y;
    end

    // Remaining tree levels down to the single winner.
    always_comb begin : stage3_tree
        logic [3:0]        wc [N2];
        logic [DISP_W-1:0] wd [N2];
        for (int i = 0; i < N2; i++) begin
            wc[i] = s2_cost[i];
            wd[i] = s2_disp[i];
        end
        for (int lvl = 0; lvl < L2; lvl++) begin
            for (int i = 0; i < (N2 >> (lvl + 1)); i++) begin
                if (wc[2*i+1] < wc[2*i]) begin
                    wc[i] = wc[2*i+1];
                    wd[i] = wd[2*i+1];
                end else begin
                    wc[i] = wc[2*i];
                    wd[i] = wd[2*i];
                end
            end
        end
        fin_cost = wc[0];
        fin_disp = wd[0];
    end

    // Output stage: result fields load only with a valid result and hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_disp  <= '0;
            out_cost  <= '0;
            out_x     <= '0;
            out_y     <= '0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_disp <= fin_disp;
                out_cost <= fin_cost;
                out_x    <= s2_x;
                out_y    <= s2_y;
            end
        end
    end

endmodule

// File: tb/tb_census_disparity.sv
// Testbench for census_disparity: table vectors, hand sequences for the
// boundary, tie and reset cases, and random streams checked against a
// queue-based reference model with per-result latency tracking.
`timescale 1ns/1ps

module tb_census_disparity;

    localparam int MAX_DISP = 16;
    localparam int DISP_W   = 4;
    localparam int ROW      = 320;

    logic              clk;
    logic              reset;
    logic [7:0]        in_left, in_right;
    logic [9:0]        in_x, in_y;
    logic              in_valid;
    logic [DISP_W-1:0] out_disp;
    logic [3:0]        out_cost;
    logic [9:0]        out_x, out_y;
    logic              out_valid;

    census_disparity #(.ROW_SZ(320), .COL_SZ(240), .MAX_DISP(MAX_DISP)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_left  (in_left),
        .in_right (in_right),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_valid (in_valid),
        .out_disp (out_disp),
        .out_cost (out_cost),
        .out_x    (out_x),
        .out_y    (out_y),
        .out_valid(out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        int disp;
        int cost;
        int x;
        int y;
    } exp_t;

    typedef struct {
        logic [7:0] left;
        logic [7:0] r0;
        logic [7:0] rh;
        int         x;
        int         exp_disp;
        int         exp_cost;
    } vec_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    logic [7:0] rq[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;
    bit         got_en = 1'b0;
    int         pulses = 0;
    logic [27:0] last_out = '0;
    int         got_d[$], got_c[$];
    int         a_d[$], a_c[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: cost per candidate straight from the rules, lowest-cost-first scan.
    task automatic model_push(input logic [7:0] l, input logic [7:0] r, input int x, input int y);
        int best_c = 99;
        int best_d = 0;
        for (int d = 0; d < MAX_DISP; d++) begin
            logic [7:0] rv;
            int c;
            rv = (d == 0) ? r : rq[d-1];
            c  = (d > x) ? 15 : $countones(l ^ rv);
            if (c < best_c) begin
                best_c = c;
                best_d = d;
            end
        end
        exp_q.push_back('{cyc + 3, best_d, best_c, x, y});
        rq.push_front(r);
        void'(rq.pop_back());
    endtask

    task automatic model_clear();
        exp_q.delete();
        rq.delete();
        for (int k = 0; k < MAX_DISP - 1; k++) rq.push_back(8'h00);
        last_out = '0;
    endtask

    task automatic drive(input logic [7:0] l, input logic [7:0] r, input int x, input int y);
        in_left  = l;
        in_right = r;
        in_x     = 10'(x);
        in_y     = 10'(y);
        in_valid = 1'b1;
        model_push(l, r, x, y);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_left  = 8'($urandom);
        in_right = 8'($urandom);
        in_x     = 10'($urandom);
        in_y     = 10'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_left  = 8'($urandom);
        in_right = 8'($urandom);
        repeat (n) @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        model_clear();
    endtask

    task automatic drain();
        repeat (5) idle();
    endtask

    function automatic logic [7:0] code(input int v);
        logic [6:0] b;
        b = 7'(v);
        return {^b, b};
    endfunction

    task automatic run_shift_rows(input bit gapped);
        for (int y = 10; y < 13; y++) begin
            for (int x = 0; x < ROW; x++) begin
                if (gapped) begin
                    for (int g = 0; g < 4 && $urandom_range(0, 99) < 40; g++) idle();
                end
                drive((x >= 5) ? code(x - 5) : ~code(x + 64), code(x), x, y);
            end
        end
        drain();
    endtask

    // Monitor: every pulse must match the model, idle cycles must hold the last result.
    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("latency", cyc, mon_e.due);
                    check("disp", 32'(out_disp), mon_e.disp);
                    check("cost", 32'(out_cost), mon_e.cost);
                    check("x", 32'(out_x), mon_e.x);
                    check("y", 32'(out_y), mon_e.y);
                end
                last_out = {out_disp, out_cost, out_x, out_y};
                if (got_en) begin
                    got_d.push_back(int'(out_disp));
                    got_c.push_back(int'(out_cost));
                end
            end else begin
                check("hold", 32'({out_disp, out_cost, out_x, out_y}), 32'(last_out));
                while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                    check("missing_valid", 0, 1);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t vecs[6];
    int   p0, bad;

    initial begin
        vecs[0] = '{8'hFF, 8'hFF, 8'h00, 5, 0, 0};
        vecs[1] = '{8'hFF, 8'h00, 8'hFF, 5, 1, 0};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 0, 0, 8};
        vecs[3] = '{8'h0F, 8'h00, 8'h03, 9, 1, 2};
        vecs[4] = '{8'hAA, 8'h55, 8'h55, 3, 0, 8};
        vecs[5] = '{8'hF0, 8'h0F, 8'hF1, 1, 1, 1};

        reset = 1'b1; in_valid = 1'b0;
        in_left = '0; in_right = '0; in_x = '0; in_y = '0;
        do_reset(3);
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_disp", 32'(out_disp), 0);
        check("reset_cost", 32'(out_cost), 0);
        check("reset_x", 32'(out_x), 0);
        check("reset_y", 32'(out_y), 0);
        @(posedge clk); #1;

        // Table vectors: fill history with rh, then one probe pixel; check held result.
        foreach (vecs[i]) begin
            for (int k = 0; k < MAX_DISP - 1; k++) drive(8'($urandom), vecs[i].rh, k, 0);
            drive(vecs[i].left, vecs[i].r0, vecs[i].x, 1);
            repeat (4) idle();
            @(negedge clk);
            check("vec_disp", 32'(out_disp), vecs[i].exp_disp);
            check("vec_cost", 32'(out_cost), vecs[i].exp_cost);
            @(posedge clk); #1;
        end

        // Tie-break: R_3 and R_9 both match exactly at x=20.
        for (int x = 0; x <= 20; x++)
            drive((x == 20) ? 8'hFF : 8'h00, (x == 11 || x == 17) ? 8'hFF : 8'h00, x, 2);
        repeat (4) idle();
        @(negedge clk);
        check("tie_disp", 32'(out_disp), 3);
        check("tie_cost", 32'(out_cost), 0);
        @(posedge clk); #1;

        // Row boundary: exact match at d=7 lives in the previous row and must be masked.
        for (int x = 0; x < ROW; x++) drive(8'($urandom), (x == 315) ? 8'h3C : 8'hC3, x, 5);
        drive(8'($urandom), 8'h3D, 0, 6);
        drive(8'($urandom), 8'h7C, 1, 6);
        drive(8'h3C, 8'h1C, 2, 6);
        repeat (4) idle();
        @(negedge clk);
        check("row_wrap_disp", 32'(out_disp), 0);
        check("row_wrap_cost", 32'(out_cost), 1);
        @(posedge clk); #1;

        // Shift by 5, gapless then gapped; sequences must be identical.
        got_d.delete(); got_c.delete(); got_en = 1'b1;
        run_shift_rows(1'b0);
        got_en = 1'b0;
        a_d = got_d; a_c = got_c;
        check("shift_count", a_d.size(), 3 * ROW);
        bad = 0;
        foreach (a_d[i]) begin
            if ((i % ROW) >= 5 && (a_d[i] != 5 || a_c[i] != 0)) bad++;
            if ((i % ROW) < 5 && a_d[i] > (i % ROW)) bad++;
        end
        check("shift_results_bad", bad, 0);
        got_d.delete(); got_c.delete(); got_en = 1'b1;
        run_shift_rows(1'b1);
        got_en = 1'b0;
        check("gap_count", got_d.size(), a_d.size());
        bad = 0;
        foreach (got_d[i]) if (i < a_d.size() && (got_d[i] != a_d[i] || got_c[i] != a_c[i])) bad++;
        check("gap_vs_gapless", bad, 0);

        // Identity frame slice: left == right everywhere.
        p0 = pulses;
        got_d.delete(); got_c.delete(); got_en = 1'b1;
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < ROW; x++) begin
                logic [7:0] v;
                v = 8'($urandom);
                drive(v, v, x, y);
            end
        end
        drain();
        got_en = 1'b0;
        check("identity_pulses", pulses - p0, 32 * ROW);
        bad = 0;
        foreach (got_d[i]) if (got_d[i] != 0 || got_c[i] != 0) bad++;
        check("identity_nonzero", bad, 0);

        // Random stream with gaps and occasional reused right codes.
        begin
            int x = 0, y = 40;
            for (int n = 0; n < 2000; n++) begin
                if ($urandom_range(0, 99) < 30) idle();
                else begin
                    logic [7:0] l;
                    l = 8'($urandom);
                    drive(l, ($urandom_range(0, 3) == 0) ? l ^ 8'(1 << $urandom_range(0, 7)) : 8'($urandom), x, y);
                    x++;
                    if (x == ROW) begin x = 0; y++; end
                end
            end
        end
        drain();

        // Reset with two results in flight; in_valid during reset is ignored.
        p0 = pulses;
        drive(8'h12, 8'h34, 100, 20);
        drive(8'h56, 8'h78, 101, 20);
        do_reset(1);
        @(negedge clk);
        check("rst_mid_valid", 32'(out_valid), 0);
        check("rst_mid_out", 32'({out_disp, out_cost, out_x, out_y}), 0);
        @(posedge clk); #1;
        drain();
        check("rst_dropped", pulses - p0, 0);
        for (int x = 0; x < 40; x++) drive(8'($urandom), 8'($urandom), x, 21);
        drain();

        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
